// File: rtl/machine_timer_if.sv
// Bus port bundle for machine_timer: single-cycle request and a registered ack/read-data response.
interface machine_timer_if;
    logic        req_i;
    logic        we_i;
    logic [31:0] addr_i;
    logic [31:0] data_i;
    logic [31:0] data_o;
    logic        ack_o;

    modport master (
        output req_i, we_i, addr_i, data_i,
        input  data_o, ack_o
    );

    modport slave (
        input  req_i, we_i, addr_i, data_i,
        output data_o, ack_o
    );
endinterface

// File: rtl/machine_timer.sv
// 64-bit machine timer with prescaler, compare match, sticky pending interrupt and optional auto-clear.
module machine_timer (
    input  logic                  clk,
    input  logic                  rst,
    machine_timer_if.slave        bus,
    output logic [7:0]            int_flag_o
);

    typedef enum logic [2:0] {
        R_CTRL     = 3'd0,
        R_PRESC    = 3'd1,
        R_MTIME_LO = 3'd2,
        R_MTIME_HI = 3'd3,
        R_CMP_LO   = 3'd4,
        R_CMP_HI   = 3'd5
    } reg_sel_e;

    logic        ctrl_en;
    logic        ctrl_ie;
    logic        ctrl_pend;
    logic        ctrl_autoclr;
    logic [15:0] presc;
    logic [15:0] pcnt;
    logic [63:0] mtime;
    logic [63:0] cmp;

    logic [2:0]  word_idx;
    logic        wr_acc;
    logic        rd_acc;
    logic        wr_ctrl;
    logic        wr_presc;
    logic        wr_mtime_lo;
    logic        wr_mtime_hi;
    logic        wr_cmp_lo;
    logic        wr_cmp_hi;
    logic        tick;
    logic        match;
    logic [31:0] rdata;
    logic        unused_addr;

    // Offsets are word-aligned; byte-lane bits and everything above bit 4 are ignored.
    assign word_idx    = bus.addr_i[4:2];
    assign unused_addr = ^{bus.addr_i[31:5], bus.addr_i[1:0]};

    assign wr_acc = bus.req_i &  bus.we_i;
    assign rd_acc = bus.req_i & ~bus.we_i;

    always_comb begin
        wr_ctrl     = 1'b0;
        wr_presc    = 1'b0;
        wr_mtime_lo = 1'b0;
        wr_mtime_hi = 1'b0;
        wr_cmp_lo   = 1'b0;
        wr_cmp_hi   = 1'b0;
        if (wr_acc) begin
            case (word_idx)
                R_CTRL:     wr_ctrl     = 1'b1;
                R_PRESC:    wr_presc    = 1'b1;
                R_MTIME_LO: wr_mtime_lo = 1'b1;
                R_MTIME_HI: wr_mtime_hi = 1'b1;
                R_CMP_LO:   wr_cmp_lo   = 1'b1;
                R_CMP_HI:   wr_cmp_hi   = 1'b1;
                default:    ;
            endcase
        end
    end

    always_comb begin
        rdata = '0;
        case (word_idx)
            R_CTRL:     rdata = {28'd0, ctrl_autoclr, ctrl_pend, ctrl_ie, ctrl_en};
            R_PRESC:    rdata = {16'd0, presc};
            R_MTIME_LO: rdata = mtime[31:0];
            R_MTIME_HI: rdata = mtime[63:32];
            R_CMP_LO:   rdata = cmp[31:0];
            R_CMP_HI:   rdata = cmp[63:32];
            default:    rdata = '0;
        endcase
    end

    assign tick  = ctrl_en && (pcnt == presc);
    assign match = (mtime >= cmp);

    always_ff @(posedge clk) begin
        if (!rst) begin
            bus.ack_o    <= 1'b0;
            bus.data_o   <= '0;
            ctrl_en      <= 1'b0;
            ctrl_ie      <= 1'b0;
            ctrl_pend    <= 1'b0;
            ctrl_autoclr <= 1'b0;
            presc        <= '0;
            pcnt         <= '0;
            mtime        <= '0;
            cmp          <= '1;
        end else begin
            bus.ack_o  <= bus.req_i;
            bus.data_o <= rd_acc ? rdata : '0;

            if (wr_ctrl) begin
                ctrl_en      <= bus.data_i[0];
                ctrl_ie      <= bus.data_i[1];
                ctrl_autoclr <= bus.data_i[3];
            end

            // A match in the same cycle beats a write-1-to-clear.
            if (match)
                ctrl_pend <= 1'b1;
            else if (wr_ctrl && bus.data_i[2])
                ctrl_pend <= 1'b0;

            if (wr_presc)
                presc <= bus.data_i[15:0];

            if (!ctrl_en)
                pcnt <= '0;
            else if (pcnt == presc)
                pcnt <= '0;
            else
                pcnt <= pcnt + 16'd1;

            // Software writes to either half take priority over counting and auto-clear.
            if (wr_mtime_lo)
                mtime[31:0] <= bus.data_i;
            else if (wr_mtime_hi)
                mtime[63:32] <= bus.data_i;
            else if (tick) begin
                if (ctrl_autoclr && match)
                    mtime <= '0;
                else
                    mtime <= mtime + 64'd1;
            end

            if (wr_cmp_lo)
                cmp[31:0] <= bus.data_i;
            if (wr_cmp_hi)
                cmp[63:32] <= bus.data_i;
        end
    end

    assign int_flag_o = {7'd0, ctrl_pend & ctrl_ie};

endmodule

// File: doc/machine_timer.md
MACHINE_TIMER -- requirements
Module: machine_timer

Interface
REQ-001 The block SHALL provide clk, input, 1, the single clock; all state changes on its rising edge.
REQ-002 The block SHALL provide rst, input, 1, reset: synchronous, active-low (rst==0 resets on the clk edge).
REQ-003 The block SHALL provide req_i, input, 1, bus access request, one access per asserted cycle.
REQ-004 The block SHALL provide we_i, input, 1, write qualifier for req_i (1 = write, 0 = read).
REQ-005 The block SHALL provide addr_i, input, 32, byte address; only addr_i[4:0] is decoded, word-aligned.
REQ-006 The block SHALL provide data_i, input, 32, write data.
REQ-007 The block SHALL provide data_o, output, 32, registered read data.
REQ-008 The block SHALL provide ack_o, output, 1, one-cycle pulse completing each access.
REQ-009 The block SHALL provide int_flag_o, output, 8, interrupt request vector to the interrupt arbiter; bit0 = timer, bits[7:1] = 0.

Function
REQ-010 The register map SHALL be:
- 0x00 CTRL: bit0 EN, bit1 IE, bit2 PEND (write-1-to-clear), bit3 AUTOCLR; other bits read 0.
- 0x04 PRESC: [15:0] divider; [31:16] read 0.
- 0x08 MTIME_LO, 0x0C MTIME_HI.
- 0x10 CMP_LO, 0x14 CMP_HI.
REQ-011 Unmapped offsets SHALL read 0 and ignore writes; both still ack.
REQ-012 Access latency SHALL be fixed: req_i in cycle N gives ack_o=1 in cycle N+1, with data_o valid in N+1 for reads and 0 for writes. data_o SHALL be 0 whenever ack_o=0.
REQ-013 A register write SHALL take effect at the clock edge ending cycle N.
REQ-014 The prescaler counter pcnt[15:0] SHALL run only while EN=1:
- pcnt==PRESC gives tick=1 and pcnt<=0; otherwise pcnt<=pcnt+1.
- PRESC=0 ticks every cycle.
- EN=0 holds pcnt at 0.
REQ-015 On tick, mtime[63:0] SHALL increment by 1 and wrap from 0xFFFF_FFFF_FFFF_FFFF to 0; a carry from the LO word SHALL propagate to HI in the same cycle.
REQ-016 The match condition SHALL be unsigned mtime >= cmp, evaluated on current register values every cycle regardless of EN.
REQ-017 PEND SHALL be set at the edge where match=1, so int_flag_o[0] rises one cycle after the match is visible, and SHALL remain set (sticky) until cleared.
REQ-018 int_flag_o[0] SHALL equal PEND & IE; int_flag_o SHALL hold level until software clears PEND.
REQ-019 With AUTOCLR=1, mtime SHALL be loaded with 0 (instead of incremented) at the edge where match=1 and tick=1.
REQ-020 Simultaneous events SHALL resolve as follows:
- A bus write to MTIME_LO/HI wins over tick increment and AUTOCLR load.
- PEND set (match) wins over a W1C in the same cycle.
- A write to CMP takes effect next cycle, and match is then re-evaluated.
REQ-021 Writing CTRL with bit2=0 SHALL leave PEND unchanged.
REQ-022 Reset values SHALL be: CMP=0xFFFF_FFFF_FFFF_FFFF, so no match occurs until mtime reaches all ones.

Reset
REQ-023 While rst=0 at a clock edge, the block SHALL clear CTRL, PRESC, pcnt, mtime, ack_o, data_o and int_flag_o to 0, and set CMP to all ones.
REQ-024 A reset asserted mid-access SHALL suppress that access's ack_o, and no register write SHALL complete.
REQ-025 One cycle after rst returns to 1, the block SHALL accept a new access.

Verification
REQ-026 Scenario, basic match: PRESC=0, CMP=10, IE=1, EN=1 -> mtime reaches 10, and int_flag_o=0x01 exactly one cycle later.
REQ-027 Scenario, prescaler: PRESC=3, EN=1 for 40 cycles -> mtime=10 (±1 for enable phase); read MTIME_LO acks one cycle after req with that value.
REQ-028 Scenario, 64-bit carry and wrap: MTIME_LO=0xFFFF_FFFF, MTIME_HI=0, one tick -> LO=0, HI=1. Then MTIME=all ones, CMP=all ones -> PEND set, and the next tick gives mtime=0.
REQ-029 Scenario, sticky pending and W1C: after a match, write CTRL=0x3 (bit2=0) -> PEND stays 1. Write CTRL=0x7 while mtime >= CMP -> PEND stays 1. Set CMP=0xFFFF_FFFF_FFFF_FFFF, then write 0x7 -> int_flag_o=0.
REQ-030 Scenario, AUTOCLR periodic: AUTOCLR=1, CMP=4, PRESC=0 -> mtime sequence 0,1,2,3,4,0,1..., and PEND is set once and remains 1.
REQ-031 Scenario, mid-operation reset: pull rst low during a write to CMP_LO -> no ack_o, CMP=all ones, mtime=0, int_flag_o=0.
